// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: state encoding,
// lamp patterns, timer interval selects and the registered output bundle.
package traffic_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAMP_W  = 3;

    // State encoding
    localparam logic [STATE_W-1:0] ST_NS_GREEN  = 3'd0;
    localparam logic [STATE_W-1:0] ST_NS_YELLOW = 3'd1;
    localparam logic [STATE_W-1:0] ST_RED_A     = 3'd2;
    localparam logic [STATE_W-1:0] ST_EW_GREEN  = 3'd3;
    localparam logic [STATE_W-1:0] ST_EW_YELLOW = 3'd4;
    localparam logic [STATE_W-1:0] ST_RED_B     = 3'd5;
    localparam logic [STATE_W-1:0] ST_PED_WALK  = 3'd6;
    localparam logic [STATE_W-1:0] ST_FAULT     = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        NS_GREEN  = ST_NS_GREEN,
        NS_YELLOW = ST_NS_YELLOW,
        RED_A     = ST_RED_A,
        EW_GREEN  = ST_EW_GREEN,
        EW_YELLOW = ST_EW_YELLOW,
        RED_B     = ST_RED_B,
        PED_WALK  = ST_PED_WALK,
        FAULT     = ST_FAULT
    } state_t;

    // Lamp vectors are {red, yellow, green}
    localparam logic [LAMP_W-1:0] LAMP_RED = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_YEL = 3'b010;
    localparam logic [LAMP_W-1:0] LAMP_GRN = 3'b001;

    localparam logic TIMER_LONG  = 1'b1;
    localparam logic TIMER_SHORT = 1'b0;

    typedef struct packed {
        logic [LAMP_W-1:0] ns;
        logic [LAMP_W-1:0] ew;
        logic              timer_select;
        logic              walk;
        logic              fault;
    } lamp_out_t;

    // Output pattern for a state; blink only matters in FAULT.
    function automatic lamp_out_t decode_outputs(input state_t st, input logic blink);
        lamp_out_t o;
        o.ns           = LAMP_RED;
        o.ew           = LAMP_RED;
        o.timer_select = TIMER_SHORT;
        o.walk         = 1'b0;
        o.fault        = 1'b0;
        case (st)
            NS_GREEN: begin
                o.ns           = LAMP_GRN;
                o.timer_select = TIMER_LONG;
            end
            NS_YELLOW: o.ns = LAMP_YEL;
            EW_GREEN: begin
                o.ew           = LAMP_GRN;
                o.timer_select = TIMER_LONG;
            end
            EW_YELLOW: o.ew = LAMP_YEL;
            PED_WALK: begin
                o.walk         = 1'b1;
                o.timer_select = TIMER_LONG;
            end
            FAULT: begin
                o.ns    = {1'b0, blink, 1'b0};
                o.ew    = {1'b0, blink, 1'b0};
                o.fault = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/traffic_wdog.sv
// Watchdog and blink source for the traffic light controller.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (clears both counters)
//   kick    : clears the watchdog count
//   expired : watchdog count has reached WDOG_CYCLES (held until kicked)
//   blink   : bit BLINK_BIT of a free-running counter
module traffic_wdog #(
    parameter int unsigned WDOG_CYCLES = 1023,
    parameter int unsigned BLINK_BIT   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic expired,
    output logic blink
);

    localparam int unsigned CW = $clog2(WDOG_CYCLES + 1);
    localparam int unsigned BW = BLINK_BIT + 1;
    localparam logic [CW-1:0] WDOG_MAX = CW'(WDOG_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_blink_cnt;

    // Idle-cycle counter; saturates so a stuck timer keeps expired asserted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (kick) begin
            r_cnt <= '0;
        end else if (r_cnt != WDOG_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Free-running blink counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign expired = (r_cnt == WDOG_MAX);
    assign blink   = r_blink_cnt[BLINK_BIT];

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller with watchdog fault mode.
// Optional pedestrian phase enabled by defining PED_REQ_EN.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (enters RED_B)
//   done_pulse   : end of current interval from traffic_timer
//   ped_req      : pedestrian request (ignored without PED_REQ_EN)
//   timer_select : 1 = long interval, 0 = short interval
//   ns_light     : north-south lamps {red, yellow, green}
//   ew_light     : east-west lamps {red, yellow, green}
//   walk         : pedestrian walk lamp
//   fault        : high while in FAULT
// All outputs are registered.
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 1023,
    parameter int unsigned BLINK_BIT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_pulse,
    input  logic              ped_req,
    output logic              timer_select,
    output logic [LAMP_W-1:0] ns_light,
    output logic [LAMP_W-1:0] ew_light,
    output logic              walk,
    output logic              fault
);

    state_t    r_state;
    state_t    w_state_nxt;
    lamp_out_t r_out;
    lamp_out_t w_out_nxt;
    logic      w_kick;
    logic      w_expired;
    logic      w_blink;
    logic      w_ped_go;
    logic      w_walk_to_ew;

    traffic_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .BLINK_BIT   (BLINK_BIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .kick    (w_kick),
        .expired (w_expired),
        .blink   (w_blink)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RED_B;
            r_out   <= decode_outputs(RED_B, 1'b0);
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Next state and next outputs; watchdog expiry wins over done_pulse
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != FAULT) begin
            if (w_expired) begin
                w_state_nxt = FAULT;
            end else if (done_pulse) begin
                case (r_state)
                    NS_GREEN:  w_state_nxt = NS_YELLOW;
                    NS_YELLOW: w_state_nxt = RED_A;
                    RED_A:     w_state_nxt = w_ped_go ? PED_WALK : EW_GREEN;
                    EW_GREEN:  w_state_nxt = EW_YELLOW;
                    EW_YELLOW: w_state_nxt = RED_B;
                    RED_B:     w_state_nxt = w_ped_go ? PED_WALK : NS_GREEN;
                    PED_WALK:  w_state_nxt = w_walk_to_ew ? EW_GREEN : NS_GREEN;
                    default:   w_state_nxt = r_state;
                endcase
            end
        end
        w_out_nxt = decode_outputs(w_state_nxt, w_blink);
        w_kick    = done_pulse || (w_state_nxt != r_state);
    end

`ifdef PED_REQ_EN
    logic r_ped;
    logic r_ped_to_ew;

    // Pedestrian latch; a request on the walk-entry edge re-arms it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped       <= 1'b0;
            r_ped_to_ew <= 1'b0;
        end else if ((w_state_nxt == PED_WALK) && (r_state != PED_WALK)) begin
            r_ped       <= ped_req;
            r_ped_to_ew <= (r_state == RED_A);
        end else if (ped_req) begin
            r_ped <= 1'b1;
        end
    end

    assign w_ped_go     = r_ped;
    assign w_walk_to_ew = r_ped_to_ew;
    assign walk         = r_out.walk;
`else
    logic w_unused_ped;
    logic w_unused_walk;

    assign w_ped_go      = 1'b0;
    assign w_walk_to_ew  = 1'b0;
    assign w_unused_ped  = ped_req;
    assign w_unused_walk = r_out.walk;
    assign walk          = 1'b0;
`endif

    assign timer_select = r_out.timer_select;
    assign ns_light     = r_out.ns;
    assign ew_light     = r_out.ew;
    assign fault        = r_out.fault;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm (WDOG_CYCLES=50, BLINK_BIT=4).
module tb_traffic_light_fsm;

    localparam int WDOG = 50;
    localparam int BB   = 4;

    logic       clk;
    logic       rst;
    logic       done_pulse;
    logic       ped_req;
    logic       timer_select;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       fault;

    int n_checks = 0;
    int n_err    = 0;

    traffic_light_fsm #(
        .WDOG_CYCLES (WDOG),
        .BLINK_BIT   (BB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .done_pulse   (done_pulse),
        .ped_req      (ped_req),
        .timer_select (timer_select),
        .ns_light     (ns_light),
        .ew_light     (ew_light),
        .walk         (walk),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PED_REQ_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase index 0..5 walks the normal six-phase cycle; lamp tables per phase.
    localparam logic [2:0] NS_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] EW_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam bit         TS_TAB [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    bit m_valid = 1'b0;
    int m_n, m_idle, m_phase, m_walk_from;
    bit m_fault, m_walk, m_ped;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_n     = 0;
            m_idle  = 0;
            m_phase = 5;
            m_fault = 1'b0;
            m_walk  = 1'b0;
            m_ped   = 1'b0;
        end else begin
            m_n++;
            if (!m_fault) begin
                if (m_idle == WDOG) begin
                    m_fault = 1'b1;
                end else if (done_pulse) begin
                    m_idle = 0;
                    if (m_walk) begin
                        m_walk  = 1'b0;
                        m_phase = (m_walk_from + 1) % 6;
                    end else if (PED_EN && m_ped && (m_phase == 2 || m_phase == 5)) begin
                        m_walk      = 1'b1;
                        m_walk_from = m_phase;
                        m_ped       = 1'b0;
                    end else begin
                        m_phase = (m_phase + 1) % 6;
                    end
                end else begin
                    m_idle++;
                end
            end
            if (PED_EN && ped_req) m_ped = 1'b1;
        end
    end

    // Per-cycle comparison against the model plus lamp safety invariants
    always @(negedge clk) begin
        logic [2:0] e_ns, e_ew;
        logic       e_ts, e_walk, e_blink;
        if (m_valid) begin
            if (m_fault) begin
                e_blink = 1'((m_n - 1) >> BB);
                e_ns    = {1'b0, e_blink, 1'b0};
                e_ew    = e_ns;
                e_ts    = 1'b0;
                e_walk  = 1'b0;
            end else if (m_walk) begin
                e_ns   = 3'b100;
                e_ew   = 3'b100;
                e_ts   = 1'b1;
                e_walk = 1'b1;
            end else begin
                e_ns   = NS_TAB[m_phase];
                e_ew   = EW_TAB[m_phase];
                e_ts   = TS_TAB[m_phase];
                e_walk = 1'b0;
            end
            check("model_ns", 32'(ns_light), 32'(e_ns));
            check("model_ew", 32'(ew_light), 32'(e_ew));
            check("model_ts", 32'(timer_select), 32'(e_ts));
            check("model_walk", 32'(walk), 32'(e_walk));
            check("model_fault", 32'(fault), 32'(m_fault));
            if (!m_fault) begin
                check("both_nonred", 32'((ns_light != 3'b100) && (ew_light != 3'b100)), 32'd0);
                check("onehot_ns", 32'($onehot(ns_light)), 32'd1);
                check("onehot_ew", 32'($onehot(ew_light)), 32'd1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle done_pulse; returns at the negedge after the transition edge
    task automatic step(input bit with_ped);
        @(negedge clk);
        done_pulse = 1'b1;
        if (with_ped) ped_req = 1'b1;
        @(negedge clk);
        done_pulse = 1'b0;
        if (with_ped) ped_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        check("rst_ns", 32'(ns_light), 32'h4);
        check("rst_ew", 32'(ew_light), 32'h4);
        check("rst_ts", 32'(timer_select), 32'h0);
        check("rst_walk", 32'(walk), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        rst = 1'b0;
    endtask

    localparam logic [2:0] SEQ_NS [7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    localparam logic [2:0] SEQ_EW [7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    localparam bit         SEQ_TS [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int k;
        bit seen0, seen1;
        rst        = 1'b1;
        done_pulse = 1'b0;
        ped_req    = 1'b0;

        // Normal cycle with done_pulse every 10 cycles
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tick(8);
            step(1'b0);
            check("seq_ns", 32'(ns_light), 32'(SEQ_NS[i]));
            check("seq_ew", 32'(ew_light), 32'(SEQ_EW[i]));
            check("seq_ts", 32'(timer_select), 32'(SEQ_TS[i]));
        end

        // Watchdog: no more done_pulse after the last kick
        k = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (fault) begin
                k = i;
                break;
            end
        end
        check("fault_latency", 32'(k), 32'd51);

        // In FAULT: done_pulse ignored, lamps blink yellow
        seen0 = 1'b0;
        seen1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            done_pulse = (i % 5 == 0);
            @(negedge clk);
            if (ns_light == 3'b010) seen1 = 1'b1;
            if (ns_light == 3'b000) seen0 = 1'b1;
        end
        done_pulse = 1'b0;
        check("fault_sticky", 32'(fault), 32'd1);
        check("blink_both", 32'({seen0, seen1}), 32'd3);

        // Reset for one cycle mid EW_YELLOW
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(8);
            step(1'b0);
        end
        check("pre_rst_ew_yel", 32'(ew_light), 32'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ns", 32'(ns_light), 32'h4);
        check("midrst_ew", 32'(ew_light), 32'h4);
        check("midrst_ts", 32'(timer_select), 32'h0);
        check("midrst_fault", 32'(fault), 32'h0);
        tick(8);
        step(1'b0);
        check("resume_ns_green", 32'(ns_light), 32'h1);

`ifdef PED_REQ_EN
        // NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN
        for (int i = 0; i < 3; i++) begin
            tick(8);
            step(1'b0);
        end
        check("ped_at_ew_green", 32'(ew_light), 32'h1);
        tick(3);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        tick(4);
        step(1'b0);                 // EW_YELLOW
        tick(8);
        step(1'b0);                 // RED_B
        check("ped_red_b_walk", 32'(walk), 32'h0);
        tick(8);
        step(1'b1);                 // PED_WALK, request re-arms latch
        check("ped_walk", 32'(walk), 32'h1);
        check("ped_walk_ts", 32'(timer_select), 32'h1);
        check("ped_walk_ns", 32'(ns_light), 32'h4);
        tick(8);
        step(1'b0);
        check("ped_exit_ns", 32'(ns_light), 32'h1);
        check("ped_exit_walk", 32'(walk), 32'h0);
        tick(8);
        step(1'b0);                 // NS_YELLOW
        tick(8);
        step(1'b0);                 // RED_A
        tick(8);
        step(1'b0);                 // PED_WALK again from kept request
        check("ped_rearm_walk", 32'(walk), 32'h1);
        tick(8);
        step(1'b0);
        check("ped_rearm_exit_ew", 32'(ew_light), 32'h1);
`else
        // ped_req held high has no effect
        ped_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(8);
            step(1'b0);
            check("noped_walk", 32'(walk), 32'h0);
        end
        check("noped_ns_green", 32'(ns_light), 32'h1);
        check("noped_ew_red", 32'(ew_light), 32'h4);
        ped_req = 1'b0;
`endif

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter WDOG_CYCLES, default 1023, is the maximum number of cycles allowed between done_pulse events before the block declares a fault.
REQ-002 Parameter BLINK_BIT, default 4, selects the free-running counter bit that drives the fault blink.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port done_pulse, input, 1 bit: one-cycle pulse from traffic_timer marking the end of the currently selected interval.
REQ-006 Port ped_req, input, 1 bit: level or pulse pedestrian crossing request.
REQ-007 Port timer_select, output, 1 bit: drives traffic_timer; 1 = long interval (green/walk), 0 = short interval (yellow/all-red).
REQ-008 Port ns_light, output, 3 bits: north-south lamps {red, yellow, green}, one-hot except in FAULT.
REQ-009 Port ew_light, output, 3 bits: east-west lamps {red, yellow, green}, same encoding as ns_light.
REQ-010 Port walk, output, 1 bit: pedestrian walk lamp.
REQ-011 Port fault, output, 1 bit: high while in FAULT.

Function
REQ-012 The FSM SHALL have states NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, PED_WALK and FAULT.
REQ-013 Normal cycle: NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> NS_GREEN; each transition happens on the rising edge after a cycle with done_pulse=1.
REQ-014 All outputs SHALL be registered and updated on the same edge the state changes; no output depends combinationally on an input.
REQ-015 timer_select SHALL be 1 in NS_GREEN, EW_GREEN and PED_WALK, and 0 in every other state.
REQ-016 Lamps: GREEN states light the green lamp on their own road and red on the other; YELLOW states light yellow on their own road and red on the other; RED_A, RED_B and PED_WALK light red on both roads.
REQ-017 walk SHALL be 1 only in PED_WALK.
REQ-018 Two conflicting greens, or a green on one road with a yellow on the other, SHALL never be driven.
REQ-019 done_pulse received in FAULT SHALL be ignored.
REQ-020 Watchdog: a cycle counter clears on every done_pulse and every state change; when it reaches WDOG_CYCLES, the next edge enters FAULT.
REQ-021 In FAULT, ns_light and ew_light SHALL be {0, blink, 0}, where blink is bit BLINK_BIT of a free-running counter; fault=1, walk=0, timer_select=0.
REQ-022 FAULT is left only by reset.
REQ-023 The watchdog counter width SHALL be $clog2(WDOG_CYCLES+1) bits, and the counter SHALL saturate rather than wrap.

Reset
REQ-024 While rst=1, the block SHALL enter RED_B with ns_light=3'b100, ew_light=3'b100, timer_select=0, walk=0 and fault=0.
REQ-025 Reset SHALL clear the watchdog counter, the blink counter and the pedestrian latch.
REQ-026 Reset asserted mid-phase SHALL abort that phase; the first green after reset release is NS_GREEN, reached after one done_pulse.

Configuration
REQ-027 With PED_REQ_EN defined, ped_req SHALL set a pedestrian latch.
REQ-028 With PED_REQ_EN defined, a done_pulse in RED_A or RED_B while the latch is set SHALL go to PED_WALK instead of the next green.
REQ-029 With PED_REQ_EN defined, PED_WALK SHALL exit on done_pulse to the green that would have followed, and the latch SHALL clear on PED_WALK entry.
REQ-030 With PED_REQ_EN defined, a ped_req in the same cycle as the PED_WALK entry edge SHALL be kept, so the latch is set again.
REQ-031 Without PED_REQ_EN, ped_req SHALL be ignored, walk SHALL be tied to 0, and PED_WALK SHALL be unreachable; the port list stays the same.

Structure
REQ-032 Shared package traffic_pkg SHALL hold the state encoding localparams (3 bits), the lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010 and LAMP_GRN=3'b001, and the TIMER_LONG and TIMER_SHORT constants.
REQ-033 The watchdog plus blink counter SHALL be one sub-module, traffic_wdog (inputs clk, rst, kick; outputs expired, blink).

Verification
REQ-034 Reset, then done_pulse every 10 cycles -> sequence RED_B, NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B, NS_GREEN; timer_select follows 0,1,0,0,1,0,0,1.
REQ-035 Each cycle, check that ns_light and ew_light are never both non-red, and that each lamp vector is one-hot outside FAULT.
REQ-036 PED_REQ_EN build: pulse ped_req for one cycle during EW_GREEN -> after RED_B, PED_WALK with walk=1 and timer_select=1, then NS_GREEN on the next done_pulse.
REQ-037 Stop done_pulse with WDOG_CYCLES=50 -> fault=1 exactly 51 cycles after the last kick; lamps blink yellow; further done_pulse has no effect.
REQ-038 Assert rst for 1 cycle in EW_YELLOW -> the next edge shows both lamps red, timer_select=0 and fault=0, and the FSM resumes at NS_GREEN.
REQ-039 Non-PED_REQ_EN build: hold ped_req=1 throughout -> normal six-state cycle, walk stays 0.
